// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the iteration count.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam int MDU_ITER = 32;

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate; used both to take operand
// magnitudes and to restore result signs.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Shift-add multiply and
// restoring divide, one bit per cycle. The divide datapath is built only
// when MDU_DIV_EN is defined; otherwise DIV/DIVU complete as a no-op.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e           state_q, state_d;
    logic [4:0]           cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 res_neg_q;
    logic                 accept, calc_start, last_iter, signed_op;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       madd;
    logic [2*WIDTH-1:0]   mult_next, prod_fix;

    assign accept    = (state_q == IDLE) && start;
`ifdef MDU_DIV_EN
    assign calc_start = accept;
`else
    assign calc_start = accept && !op[1];
`endif
    assign last_iter = (cnt_q == 5'(MDU_ITER - 1));
    assign busy      = (state_q != IDLE);
    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign neg_a     = signed_op && a[WIDTH-1];
    assign neg_b     = signed_op && b[WIDTH-1];

    mdu_signfix #(.W(WIDTH)) u_sf_a (.din(a), .neg(neg_a), .dout(mag_a));
    mdu_signfix #(.W(WIDTH)) u_sf_b (.din(b), .neg(neg_b), .dout(mag_b));
    mdu_signfix #(.W(2*WIDTH)) u_sf_prod (.din(acc_q), .neg(res_neg_q), .dout(prod_fix));

    // Low half of acc_q starts as the multiplier and is shifted out as the
    // product's low bits are shifted in.
    assign madd      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mult_next = {madd, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic             is_div_q, rem_neg_q;
    logic [WIDTH:0]   rem_q, shifted, diff;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd_q};

    mdu_signfix #(.W(WIDTH)) u_sf_quo (.din(acc_q[WIDTH-1:0]), .neg(res_neg_q), .dout(quo_fix));
    // A zero divisor leaves |a| in the remainder, so HI recovers the original a.
    mdu_signfix #(.W(WIDTH)) u_sf_rem (.din(rem_q[WIDTH-1:0]), .neg(rem_neg_q), .dout(rem_fix));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (calc_start) state_d = CALC;
            CALC:    if (last_iter)  state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            res_neg_q   <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MDU_DIV_EN
            is_div_q    <= 1'b0;
            rem_neg_q   <= 1'b0;
            rem_q       <= '0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (calc_start) begin
                        cnt_q     <= '0;
                        res_neg_q <= neg_a ^ neg_b;
`ifdef MDU_DIV_EN
                        is_div_q  <= op[1];
                        rem_neg_q <= neg_a;
                        rem_q     <= '0;
`endif
                        if (op[1]) begin
                            opnd_q <= mag_b;
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opnd_q <= mag_a;
                            acc_q  <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end else if (accept) begin
                        done <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
`ifdef MDU_DIV_EN
                    if (is_div_q) begin
                        rem_q              <= diff[WIDTH] ? shifted : diff;
                        acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], ~diff[WIDTH]};
                    end else
`endif
                    acc_q <= mult_next;
                end
                FIX: begin
                    done <= 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div_q) begin
                        hi          <= rem_fix;
                        lo          <= (opnd_q == '0) ? '1 : quo_fix;
                        div_by_zero <= (opnd_q == '0);
                    end else
`endif
                    begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] a_i = '0, b_i = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] cur_hi = '0, cur_lo = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("done_without_request", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", dbz, e.dbz);
            end
        end
    end

    // Called at a negedge; the op is sampled at the next posedge (E0) and
    // done becomes visible after E33.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, y,
                         input logic [31:0] h, l, input logic z);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = z; e.cyc = cyc + 34;
        sb.push_back(e);
        cur_hi = h; cur_lo = l;
        start = 1'b1; op_i = o; a_i = x; b_i = y;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, y,
                       input logic [31:0] h, l, input logic z);
        issue(o, x, y, h, l, z);
        wait_idle();
    endtask

    task automatic div_op(input logic [1:0] o, input logic [31:0] x, y,
                          input logic [31:0] h, l, input logic z);
`ifdef MDU_DIV_EN
        run(o, x, y, h, l, z);
`else
        exp_t e;
        e.hi = cur_hi; e.lo = cur_lo; e.dbz = 1'b0; e.cyc = cyc + 1;
        sb.push_back(e);
        start = 1'b1; op_i = o; a_i = x; b_i = y;
        @(negedge clk);
        start = 1'b0;
        chk("div_off_busy", busy, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;
        @(negedge clk);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5678;
        chk("mthi", hi, 32'h0000_1234);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h0000_5678);

        // MULT -3*7 with MTLO alongside start (dropped) and MTHI mid-op (ignored)
        lo_we = 1'b1; wdata = 32'h0000_BEEF;
        issue(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        lo_we = 1'b0;
        chk("mtlo_with_start_dropped", lo, 32'h0000_5678);
        repeat (10) @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_mid_op_ignored", hi, 32'h0000_1234);
        wait_idle();

        // Back-to-back ops issued in the done cycle
        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

        // start while busy must be ignored
        issue(2'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; op_i = 2'd3; a_i = 32'd1; b_i = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        div_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        div_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        div_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        div_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        div_op(2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        div_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // MULT after a DIV (or DIV no-op) still behaves
        run(2'd0, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

        // Reset at iteration ~10 aborts the op and clears HI/LO
        issue(2'd0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        repeat (9) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        cur_hi = '0; cur_lo = '0;
        @(negedge clk);
        run(2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, fed from the same ID/EX operand path as the ALU. It takes over the MULT/MULTU/DIV/DIVU work so the ALU's combinational `*` and `/` paths can be retired. It owns the architectural HI/LO registers, whose values reach the ALU through its forward operation (code 12) for MFHI/MFLO. Upstream stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a result.
- `div_by_zero`  out  1  qualified by `done`; divisor was 0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO.

## Operation
- Reset: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; FSM goes to IDLE. Reset mid-operation aborts it and leaves HI/LO at 0.
- States: IDLE → CALC (exactly WIDTH iterations, counted by a 5-bit counter) → FIX → IDLE.
- IDLE, `start`=1:
  - latch `a`, `b` and `op`;
  - signed ops load magnitudes |a|, |b| and record sign flags;
  - go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- FIX:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] / remainder and LO = product[31:0] / quotient.
  - Pulse `done`.
- Divide by zero: HI = `a` (original), LO = all-ones, `div_by_zero`=1 with `done`. No trap.
- Signed overflow: -2^31 / -1 gives LO = 0x80000000, HI = 0, `div_by_zero`=0.
- `start` while `busy`: ignored, not queued.
- `hi_we`/`lo_we`:
  - applied in IDLE only;
  - ignored while `busy`;
  - if asserted in the same cycle `start` is accepted, the write is dropped.

## Timing
- `start` sampled at edge E0; `busy`=1 from E0 through E33.
- Edges E1..E32 perform the 32 iterations. E33 is FIX: HI/LO update, `busy` falls, `done`=1 for that one cycle.
- Back-to-back: a new `start` is accepted in the cycle `done` is high. Effective throughput is 34 cycles per op.
- `hi`/`lo` are registered outputs. MTHI/MTLO results are visible the cycle after the write edge.
- `done` and `div_by_zero` are registered, so they carry no combinational path from the inputs.

## Configuration
- `MDU_DIV_EN` defined:
  - full behaviour as above.
- `MDU_DIV_EN` undefined:
  - divide datapath is not built;
  - DIV/DIVU with `start` give `done`=1 one cycle later with `busy` staying 0;
  - HI/LO are unchanged and `div_by_zero`=0;
  - MULT/MULTU are unaffected.

## Structure
- `mdu_pkg` holds:
  - op encodings `MDU_MULT`/`MDU_MULTU`/`MDU_DIV`/`MDU_DIVU`;
  - FSM state enum (IDLE, CALC, FIX);
  - `MDU_ITER` = 32.
- One sub-module, `mdu_signfix`: combinational conditional two's-complement negate, shared by operand load and FIX.
- FSM, counter and HI/LO registers live in the top.

## Test plan
- MULT a=-3 (0xFFFFFFFD), b=7 → after 34 cycles: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulse exactly at E33.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV a=0x80000000, b=-1 → LO=0x80000000, HI=0.
- DIVU a=100, b=0 → HI=100, LO=0xFFFFFFFF, `div_by_zero`=1. With `MDU_DIV_EN` undefined → `done` after 1 cycle, HI/LO unchanged.
- MTHI 0x1234 in IDLE, then `start` and `hi_we` pulsed mid-operation → HI=0x1234 before the op; mid-op writes are ignored; final HI is the op result.
- `rst` asserted at iteration 10 of a MULT → `busy`=0, HI=LO=0 immediately. A following `start` completes normally in 34 cycles.
